// File: rtl/kp_disp_pkg.sv
// kp_disp_pkg: shared key codes, blank glyph and key/segment helpers for the keypad display path
package kp_disp_pkg;
  localparam logic [3:0] KEY_STAR  = 4'd10;
  localparam logic [3:0] KEY_HASH  = 4'd11;
  localparam logic [6:0] SEG_BLANK = 7'b0;
  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'd0:    glyph = 7'b1111110;
      4'd1:    glyph = 7'b0110000;
      4'd2:    glyph = 7'b1101101;
      4'd3:    glyph = 7'b1111001;
      4'd4:    glyph = 7'b0110011;
      4'd5:    glyph = 7'b1011011;
      4'd6:    glyph = 7'b1011111;
      4'd7:    glyph = 7'b1110010;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1111011;
      default: glyph = SEG_BLANK;
    endcase
  endfunction
  // bits 0..8 are keys 1..9, bit9 is key 0, bits 10/11 map straight to their codes
  function automatic logic [3:0] onehot_to_code(input logic [11:0] k);
    onehot_to_code = 4'd0;
    for (int i = 0; i < 12; i++)
      if (k[i]) onehot_to_code = (i < 9) ? 4'(i + 1) : (i == 9) ? 4'd0 : 4'(i);
  endfunction
endpackage

// File: rtl/seg_scan.sv
// seg_scan: cycles a one-hot digit enable with a programmable dwell and muxes the packed shadow onto it
module seg_scan
  import kp_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_DIGITS*7-1:0]   i_shadow,
  input  logic                      i_disp_valid,
  output logic [6:0]                o_data_out,
  output logic [NUM_DIGITS-1:0]     o_data_pos
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [IW-1:0] r_idx;
  logic [DW-1:0] r_div;
  logic          w_tc;
  assign w_tc = r_div == DW'(SCAN_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_div      <= '0;
      o_data_pos <= '0;
      o_data_out <= SEG_BLANK;
    end else begin
      r_div      <= w_tc ? '0 : r_div + 1'b1;
      if (w_tc) r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      o_data_pos <= NUM_DIGITS'(1) << r_idx;
      o_data_out <= i_disp_valid ? i_shadow[r_idx*7 +: 7] : SEG_BLANK;
    end
  end
endmodule

// File: rtl/keypad_digit_display.sv
// keypad_digit_display: keypad press detector, N-digit edit buffer with write pointer,
// '*' commit to a display shadow, and multiplexed 7-segment scan of that shadow
module keypad_digit_display
  import kp_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 4,
  parameter int AUTO_ADVANCE = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [11:0]                   keypad_in,
  output logic                          key_valid,
  output logic [3:0]                    key_code,
  output logic [$clog2(NUM_DIGITS)-1:0] wr_ptr,
  output logic                          ptr_wrap,
  output logic                          disp_valid,
  output logic [6:0]                    data_out,
  output logic [NUM_DIGITS-1:0]         data_pos
);
  localparam int PW = $clog2(NUM_DIGITS);
  logic [11:0]             r_key_q, r_key_p;
  logic [NUM_DIGITS*7-1:0] r_buf, r_shadow;
  logic w_accept, w_digit, w_adv, w_last;
  // a press needs exactly one key down now and a fully released pad the cycle before
  assign w_accept = (r_key_q != '0) && ((r_key_q & (r_key_q - 12'd1)) == '0) && (r_key_p == '0);
  assign w_digit  = key_valid && key_code <= 4'd9;
  assign w_adv    = (key_valid && key_code == KEY_HASH) || (AUTO_ADVANCE != 0 && w_digit);
  assign w_last   = wr_ptr == PW'(NUM_DIGITS - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_q    <= '0;
      r_key_p    <= '0;
      r_buf      <= '0;
      r_shadow   <= '0;
      key_valid  <= 1'b0;
      key_code   <= 4'd0;
      wr_ptr     <= '0;
      ptr_wrap   <= 1'b0;
      disp_valid <= 1'b0;
    end else begin
      r_key_q   <= keypad_in;
      r_key_p   <= r_key_q;
      key_valid <= w_accept;
      if (w_accept) key_code <= onehot_to_code(r_key_q);
      ptr_wrap  <= w_adv && w_last;
      if (w_adv) wr_ptr <= w_last ? '0 : wr_ptr + 1'b1;
      if (w_digit) r_buf[wr_ptr*7 +: 7] <= glyph(key_code);
      if (key_valid && key_code == KEY_STAR) begin
        r_shadow   <= r_buf;
        disp_valid <= 1'b1;
      end
    end
  end
  seg_scan #(.NUM_DIGITS(NUM_DIGITS), .SCAN_DIV(SCAN_DIV)) u_scan (
    .clk          (clk),
    .rst          (rst),
    .i_shadow     (r_shadow),
    .i_disp_valid (disp_valid),
    .o_data_out   (data_out),
    .o_data_pos   (data_pos)
  );
endmodule
